// File: rtl/digit_scan_driver.sv
// digit_scan_driver: multiplexed seven-segment scanner.
//
// Walks an active-low one-hot digit select across DIGITS positions, one slot of
// CLK_DIV cycles per digit. The first BLANK_CYCLES cycles of each slot keep all
// selects off so the previous digit's segments cannot ghost onto the next one.
// Display data is captured once per frame, so a digit never changes mid-frame.
//
// Optional feature: define DIGIT_SCAN_DIMMING_EN to add a 16-step brightness
// input that gates the drive with a free-running 4-bit phase counter.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           scan enable; low blanks the display and freezes the scan
//   digit_data   packed 4-bit codes, digit i at [4i+3:4i]
//   blank_mask   1 = digit i dark for its whole slot
//   dp_mask      1 = decimal point lit on digit i
//   bright       (dimming build only) lit phases 0..bright of every 16 cycles
//   sel          active-low digit select, at most one bit low
//   seg          active-low segments {dp,g,f,e,d,c,b,a}
//   scan_idx     digit position currently addressed
//   frame_start  one-cycle pulse when the scan wraps back to digit 0
module digit_scan_driver #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [4*DIGITS-1:0]        digit_data,
    input  logic [DIGITS-1:0]          blank_mask,
    input  logic [DIGITS-1:0]          dp_mask,
`ifdef DIGIT_SCAN_DIMMING_EN
    input  logic [3:0]                 bright,
`endif
    output logic [DIGITS-1:0]          sel,
    output logic [7:0]                 seg,
    output logic [$clog2(DIGITS)-1:0]  scan_idx,
    output logic                       frame_start
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned P_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [P_W-1:0]    P_LAST   = P_W'(CLK_DIV - 1);
    localparam logic [P_W-1:0]    P_LIT    = P_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_D0   = {{(DIGITS-1){1'b0}}, 1'b1};

    // Active-low {g,f,e,d,c,b,a}; A-F use the usual mixed-case glyphs.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [P_W-1:0]      p_q, p_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                frame_start_q, frame_start_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;
    logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
    logic [DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    // Set by reset so the first enabled cycle captures real data.
    logic                load_pend_q, load_pend_d;

    logic                slot_end;
    logic                frame_wrap;
    logic                snap_load;
    logic                drive;
    logic                dim_ok;
    logic [3:0]          cur_code;

`ifdef DIGIT_SCAN_DIMMING_EN
    logic [3:0]          q_q, q_d;

    always_comb begin
        q_d    = en ? q_q + 4'd1 : q_q;
        dim_ok = (q_q <= bright);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end
`else
    assign dim_ok = 1'b1;
`endif

    always_comb begin
        slot_end   = (p_q == P_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);
        snap_load  = en && (load_pend_q || frame_wrap);

        p_d           = p_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        load_pend_d   = load_pend_q && !en;
        snap_data_d   = snap_data_q;
        snap_blank_d  = snap_blank_q;
        snap_dp_d     = snap_dp_q;

        if (en) begin
            if (slot_end) begin
                p_d   = '0;
                idx_d = frame_wrap ? '0 : idx_q + 1'b1;
            end else begin
                p_d = p_q + 1'b1;
            end
            frame_start_d = frame_wrap;
        end

        if (snap_load) begin
            snap_data_d  = digit_data;
            snap_blank_d = blank_mask;
            snap_dp_d    = dp_mask;
        end

        // Outputs are registered from the current (pre-update) scan state.
        cur_code = snap_data_q[{idx_q, 2'b00} +: 4];
        drive    = en && (p_q >= P_LIT) && !snap_blank_q[idx_q] && dim_ok;

        sel_d = '1;
        seg_d = 8'hFF;
        if (drive) begin
            sel_d = ~(SEL_D0 << idx_q);
            seg_d = {~snap_dp_q[idx_q], seg_decode(cur_code)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q           <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            sel_q         <= '1;
            seg_q         <= 8'hFF;
            snap_data_q   <= '0;
            snap_blank_q  <= '0;
            snap_dp_q     <= '0;
            load_pend_q   <= 1'b1;
        end else begin
            p_q           <= p_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            snap_data_q   <= snap_data_d;
            snap_blank_q  <= snap_blank_d;
            snap_dp_q     <= snap_dp_d;
            load_pend_q   <= load_pend_d;
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign scan_idx    = idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2).
// A cycle model pushes expected outputs before each clock edge; they are popped
// and compared one step after the edge. Table vectors and hand sequences cover
// decode, masks, snapshot timing, enable freeze and mid-slot reset.
module tb_digit_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] digit_data;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [1:0]  scan_idx;
    logic        frame_start;
`ifdef DIGIT_SCAN_DIMMING_EN
    logic [3:0]  bright;
    assign bright = 4'hF;
`endif

    digit_scan_driver #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digit_data  (digit_data),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
`ifdef DIGIT_SCAN_DIMMING_EN
        .bright      (bright),
`endif
        .sel         (sel),
        .seg         (seg),
        .scan_idx    (scan_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [31:0] seg_exp;
        logic [15:0] sel_exp;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  dec_tab [16];
    vec_t        vecs [6];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Reference model state
    int          m_p;
    int          m_idx;
    bit          m_first;
    logic [15:0] m_data;
    logic [3:0]  m_blank;
    logic [3:0]  m_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        exp_t e;
        bit   fs;
        e  = {4'hF, 8'hFF, 2'd0, 1'b0};
        fs = 1'b0;
        if (rst) begin
            m_p = 0; m_idx = 0; m_first = 1'b1;
            m_data = '0; m_blank = '0; m_dp = '0;
        end else begin
            if (en && m_p >= BLANK && !m_blank[m_idx]) begin
                e.sel = ~(4'b0001 << m_idx);
                e.seg = {~m_dp[m_idx], dec_tab[m_data[4*m_idx +: 4]][6:0]};
            end
            if (en) begin
                if (m_p == CLK_DIV - 1) begin
                    m_p = 0;
                    if (m_idx == DIGITS - 1) begin
                        m_idx = 0;
                        fs    = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_p++;
                end
                if (m_first || fs) begin
                    m_data = digit_data; m_blank = blank_mask; m_dp = dp_mask;
                end
                m_first = 1'b0;
            end
            e.idx = 2'(m_idx);
            e.fs  = fs;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check("sb_sel", 32'(sel), 32'(e.sel));
        check("sb_seg", 32'(seg), 32'(e.seg));
        check("sb_scan_idx", 32'(scan_idx), 32'(e.idx));
        check("sb_frame_start", 32'(frame_start), 32'(e.fs));
    endtask

    // Returns in the cycle frame_start is high (frame cycle t=0).
    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (frame_start === 1'b1) found = 1'b1;
        end
        check("frame_timeout", 32'(found), 32'd1);
    endtask

    // From t=0 of a frame, digit d is shown with p=4 at cycle t=8d+5.
    task automatic sample_frame(input string name, input logic [31:0] segs,
                                input logic [15:0] sels);
        for (int t = 1; t < DIGITS * CLK_DIV; t++) begin
            tick();
            if (t % CLK_DIV == 5) begin
                check({name, "_sel"}, 32'(sel), 32'(sels[4*(t/CLK_DIV) +: 4]));
                check({name, "_seg"}, 32'(seg), 32'(segs[8*(t/CLK_DIV) +: 8]));
            end
        end
    endtask

    initial begin
        int last_fs;
        int lit_cnt;
        bit seen;

        dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vecs[0] = '{16'h4321, 4'b0000, 4'b0000, {8'h99, 8'hB0, 8'hA4, 8'hF9}, 16'h7BDE};
        vecs[1] = '{16'h4321, 4'b0100, 4'b0001, {8'h99, 8'hFF, 8'hA4, 8'h79}, 16'h7FDE};
        vecs[2] = '{16'h8888, 4'b0000, 4'b0000, {8'h80, 8'h80, 8'h80, 8'h80}, 16'h7BDE};
        vecs[3] = '{16'hFEDC, 4'b0000, 4'b1010, {8'h0E, 8'h86, 8'h21, 8'hC6}, 16'h7BDE};
        vecs[4] = '{16'hBA98, 4'b1001, 4'b0110, {8'hFF, 8'h08, 8'h10, 8'hFF}, 16'hFBDF};
        vecs[5] = '{16'h7650, 4'b0000, 4'b0000, {8'hF8, 8'h82, 8'h92, 8'hC0}, 16'h7BDE};

        m_p = 0; m_idx = 0; m_first = 1'b1; m_data = '0; m_blank = '0; m_dp = '0;
        rst = 1'b1; en = 1'b0;
        digit_data = 16'h4321; blank_mask = '0; dp_mask = '0;

        // Reset held 3 cycles: outputs dark, index 0, no frame pulse.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sel", 32'(sel), 32'hF);
            check("rst_seg", 32'(seg), 32'hFF);
        end
        rst = 1'b0;
        en  = 1'b1;

        // Free scan: frame_start period must be DIGITS*CLK_DIV.
        last_fs = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'd32);
                last_fs = cyc;
            end
        end

        // Table-driven frames: inputs apply from the next frame boundary.
        for (int v = 0; v < 6; v++) begin
            digit_data = vecs[v].data;
            blank_mask = vecs[v].blank;
            dp_mask    = vecs[v].dp;
            wait_frame();
            sample_frame("vec", vecs[v].seg_exp, vecs[v].sel_exp);
        end

        // Snapshot: change data while digit 1 is addressed.
        digit_data = 16'h4321; blank_mask = '0; dp_mask = '0;
        wait_frame();
        wait_frame();
        for (int t = 1; t <= 8; t++) tick();
        check("snap_idx", 32'(scan_idx), 32'd1);
        digit_data = 16'h8888;
        for (int t = 9; t < 32; t++) begin
            tick();
            if (t % 8 == 5) check("snap_old_seg", 32'(seg), 32'(dec_tab[t / 8 + 1]));
        end
        wait_frame();
        sample_frame("snap_new", {8'h80, 8'h80, 8'h80, 8'h80}, 16'h7BDE);

        // Enable freeze at p=5 of digit 1; digit 1 still gets 6 lit cycles in total.
        digit_data = 16'h4321;
        wait_frame();
        wait_frame();
        lit_cnt = 0;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (sel === 4'hD) lit_cnt++;
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("dis_sel", 32'(sel), 32'hF);
            check("dis_seg", 32'(seg), 32'hFF);
            check("dis_idx", 32'(scan_idx), 32'd1);
        end
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (sel === 4'hD) lit_cnt++;
            if (sel === 4'hB) seen = 1'b1;
        end
        check("resume_next_digit", 32'(seen), 32'd1);
        check("resume_lit_cycles", 32'(lit_cnt), 32'd6);

        // Mid-slot reset, then scan restarts from digit 0 after the blank time.
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check("mrst_idx", 32'(scan_idx), 32'd0);
        check("mrst_sel", 32'(sel), 32'hF);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
